// File: rtl/t_ff_pkg.sv
// t_ff_pkg: shared defaults and types for the toggle flip-flop bank
package t_ff_pkg;
    localparam int DEF_WIDTH = 1;
    localparam int DEF_CNT_W = 8;
    typedef logic [DEF_CNT_W-1:0] cnt_t;
endpackage

// File: rtl/t_ff_bit.sv
// t_ff_bit: single-bit toggle flop; clk, rst (sync, active-high), rst_val loaded on reset, t toggle request, q state
module t_ff_bit (
    input  logic clk,
    input  logic rst,
    input  logic rst_val,
    input  logic t,
    output logic q
);
    always_ff @(posedge clk)
        q <= rst ? rst_val : q ^ t;
endmodule

// File: rtl/t_ff.sv
// t_ff: WIDTH-bit toggle flip-flop bank; clk, rst (sync, active-high), t per-bit toggle, q state, q_n = ~q,
// toggle_cnt saturating count of toggling edges when T_FF_TOGGLE_CNT_EN is defined
module t_ff
    import t_ff_pkg::*;
#(
    parameter int               WIDTH   = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0
`ifdef T_FF_TOGGLE_CNT_EN
    ,
    parameter int               CNT_W   = DEF_CNT_W
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n
`ifdef T_FF_TOGGLE_CNT_EN
    ,
    output logic [CNT_W-1:0] toggle_cnt
`endif
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        t_ff_bit u_bit (
            .clk     (clk),
            .rst     (rst),
            .rst_val (RST_VAL[i]),
            .t       (t[i]),
            .q       (q[i])
        );
    end
    assign q_n = ~q;
`ifdef T_FF_TOGGLE_CNT_EN
    // counts edges where any bit toggled; holds at all-ones instead of wrapping
    always_ff @(posedge clk)
        if (rst)
            toggle_cnt <= '0;
        else if (|t && !(&toggle_cnt))
            toggle_cnt <= toggle_cnt + CNT_W'(1);
`endif
endmodule

// File: tb/tb_t_ff.sv
// tb_t_ff: directed self-checking bench for t_ff (single-bit, 4-bit, and counter builds)
module tb_t_ff;
    logic       clk = 1'b0;
    logic       rst;
    logic       t1;
    logic [3:0] t4;
    logic       q1, qn1;
    logic [3:0] q4, qn4;
    int         n_chk = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    t_ff u_dut (.clk(clk), .rst(rst), .t(t1), .q(q1), .q_n(qn1));

    t_ff #(.WIDTH(4), .RST_VAL(4'b1010)) u_wide (.clk(clk), .rst(rst), .t(t4), .q(q4), .q_n(qn4));

`ifdef T_FF_TOGGLE_CNT_EN
    logic       tc;
    logic       qc, qnc;
    logic [1:0] cnt;
    t_ff #(.CNT_W(2)) u_cnt (.clk(clk), .rst(rst), .t(tc), .q(qc), .q_n(qnc), .toggle_cnt(cnt));
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        t1  = 1'b0;
        t4  = 4'b0000;
`ifdef T_FF_TOGGLE_CNT_EN
        tc  = 1'b0;
`endif
        tick();
        check("rst_q", 32'(q1), 32'h0);
        check("rst_qn", 32'(qn1), 32'h1);
        check("rst_wide_q", 32'(q4), 32'ha);
        check("rst_wide_qn", 32'(qn4), 32'h5);
        rst = 1'b0;
        tick();
        check("idle_q", 32'(q1), 32'h0);
        t1 = 1'b1;
        tick();
        check("tog1_q", 32'(q1), 32'h1);
        check("tog1_qn", 32'(qn1), 32'h0);
        tick();
        check("tog2_q", 32'(q1), 32'h0);
        t1 = 1'b0;
        tick();
        check("hold0_a", 32'(q1), 32'h0);
        tick();
        check("hold0_b", 32'(q1), 32'h0);
        t1 = 1'b1;
        tick();
        check("pre_prio_q", 32'(q1), 32'h1);
        rst = 1'b1;
        tick();
        check("prio_q", 32'(q1), 32'h0);
        check("prio_qn", 32'(qn1), 32'h1);
        check("prio_wide_q", 32'(q4), 32'ha);
        rst = 1'b0;
        tick();
        check("post_rst_q", 32'(q1), 32'h1);
        t1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold1_q", 32'(q1), 32'h1);
            check("hold1_qn", 32'(qn1), 32'h0);
        end
        // a t pulse that falls before the next edge must be ignored
        @(negedge clk);
        t1 = 1'b1;
        #2;
        t1 = 1'b0;
        tick();
        check("glitch_q", 32'(q1), 32'h1);
        t4 = 4'b0110;
        tick();
        check("wide_tog_q", 32'(q4), 32'hc);
        check("wide_tog_qn", 32'(qn4), 32'h3);
        t4 = 4'b1111;
        tick();
        check("wide_all_q", 32'(q4), 32'h3);
        t4 = 4'b0000;
        tick();
        check("wide_hold_q", 32'(q4), 32'h3);
`ifdef T_FF_TOGGLE_CNT_EN
        rst = 1'b1;
        tick();
        check("cnt_rst", 32'(cnt), 32'h0);
        rst = 1'b0;
        tc  = 1'b1;
        tick();
        check("cnt_1", 32'(cnt), 32'h1);
        tick();
        check("cnt_2", 32'(cnt), 32'h2);
        tick();
        check("cnt_3", 32'(cnt), 32'h3);
        tick();
        check("cnt_sat_a", 32'(cnt), 32'h3);
        tick();
        check("cnt_sat_b", 32'(cnt), 32'h3);
        check("cnt_q", 32'(qc), 32'h1);
        rst = 1'b1;
        tick();
        check("cnt_clr", 32'(cnt), 32'h0);
        rst = 1'b0;
        tc  = 1'b0;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/t_ff.md
Name: t_ff

Overview:
- Synchronous toggle flip-flop bank: each bit of q inverts on a rising clock edge when its t bit is high, and holds otherwise.
- Leaf storage primitive, used for dividers, parity trackers and toggling control flags.
- The default configuration (WIDTH=1) is the classic single T flip-flop.

Parameters:
- WIDTH, 1, number of independent toggle bits (>=1).
- RST_VAL, all zeros, WIDTH-bit value loaded into q on reset.
- CNT_W, 8, width of the toggle counter; used only when T_FF_TOGGLE_CNT_EN is defined.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- t  input  WIDTH  per-bit toggle request.
- q  output  WIDTH  registered state.
- q_n  output  WIDTH  bitwise complement of q, purely combinational from q.

Behaviour:
- One clock; reset is synchronous and active-high. Reset is sampled only at the rising edge of clk; there is no asynchronous path.
- Rising edge with rst=1: q <= RST_VAL. Reset has priority over t.
- Rising edge with rst=0: q <= q ^ t, bitwise.
  - t[i]=0: bit holds.
  - t[i]=1: bit inverts.
- Latency: q reflects a toggle one edge after t is sampled high.
- t held high for N consecutive edges toggles the bit N times. Even N leaves the original value; odd N leaves the inverted value.
- q_n == ~q at all times, including during reset.
- Reset mid-operation: the edge with rst=1 forces RST_VAL regardless of t. The first edge after rst falls applies t normally.
- Before the first reset edge, q is unspecified (X in simulation). No initial blocks are used for synthesis state.
- No combinational path from t to q or q_n.
- t changing between edges has no effect; only the value at the edge matters.

Optional Feature:
- Macro: T_FF_TOGGLE_CNT_EN.
- Defined: adds output toggle_cnt [CNT_W-1:0], registered.
  - Reset (rst=1) clears it to 0.
  - Otherwise it increments on every edge where rst=0 and t is non-zero, i.e. at least one bit toggled.
  - Saturates at all-ones and never wraps.
- Undefined: the port and its counter logic are absent; the behaviour of q and q_n is identical in both builds.

Decomposition:
- Shared package t_ff_pkg:
  - default WIDTH and CNT_W constants;
  - typedef for the counter type, cnt_t.
- Natural sub-module: t_ff_bit, a single-bit toggle flop with clk, rst, rst_val, t and q. The top generate-loops WIDTH instances and adds q_n and the optional counter.

Test Plan:
- Reset with WIDTH=1, RST_VAL=0, period 10 ns: clk=0, rst=1, t=0; first edge at 5 ns -> q=0, q_n=1. rst=0 at 10 ns, t=0 -> q stays 0 on the edge at 15 ns.
- Toggle sequence: t=1 from 20 ns to 40 ns -> edge at 25 ns gives q=1, edge at 35 ns gives q=0. t=0 at 40 ns -> q holds 0 on the edges at 45 and 55 ns.
- Reset priority: q=1, then rst=1 and t=1 on the same edge -> q=0 (RST_VAL), not 1 or toggled.
- Hold: t=0 for 5 edges with q=1 -> q stays 1 throughout. q_n stays 0 at all times.
- Multi-bit: WIDTH=4, RST_VAL=4'b1010; after reset, t=4'b0110 for one edge -> q=4'b1100.
- Counter (T_FF_TOGGLE_CNT_EN, CNT_W=2): reset, then t non-zero for 5 edges -> toggle_cnt reads 1, 2, 3, 3, 3 (saturates). rst=1 -> 0.
